// File: rtl/ws_systolic_array.sv
// ws_systolic_array: weight-stationary NxN systolic matrix-multiply engine, y = x*W
// Ports: clk, reset (async, active-high)
//        load_weights/w_in   one weight row per beat, rows 0..N-1 in order
//        weights_valid       full matrix loaded, activations may be accepted
//        x_valid/x_in/x_ready  one activation row-vector per cycle
//        y_valid/y_out       result vector, one pulse per accepted x, 2N cycles later
//        busy                accepted activations still in the array
module ws_systolic_array #(
    parameter int N = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH = 2*DATA_WIDTH+$clog2(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_weights,
    input  logic [N*DATA_WIDTH-1:0] w_in,
    output logic weights_valid,
    input  logic x_valid,
    input  logic [N*DATA_WIDTH-1:0] x_in,
    output logic x_ready,
    output logic y_valid,
    output logic [N*ACC_WIDTH-1:0] y_out,
    output logic busy
);
    localparam int CW = $clog2(N);
    localparam int PW = 2*DATA_WIDTH;
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
    state_t state, state_nx;
    logic [CW-1:0] row_cnt, row_sel;
    logic cap, accept;
    logic [2*N-2:0] vld;
    logic signed [DATA_WIDTH-1:0] w [N][N];
    logic signed [DATA_WIDTH-1:0] ent [N];
    logic signed [DATA_WIDTH-1:0] ar [N][N-1];
    logic signed [ACC_WIDTH-1:0] p [N][N];
    logic signed [ACC_WIDTH-1:0] col [N];

    assign weights_valid = state == READY;
    assign x_ready = weights_valid && !load_weights;
    assign accept = x_valid && x_ready;
    // a reload from EMPTY/READY is refused while results are in flight, so
    // the weights never change under an accepted activation
    assign cap = load_weights && (state == LOADING || !busy);
    assign row_sel = state == LOADING ? row_cnt : '0;
    assign busy = |vld;

    always_comb begin
        state_nx = !cap ? state : (state == LOADING && row_cnt == CW'(N-1)) ? READY : LOADING;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            row_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cap)
                row_cnt <= state_nx == READY ? '0 : row_sel + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    w[r][c] <= '0;
        end else if (cap) begin
            for (int c = 0; c < N; c++)
                w[row_sel][c] <= w_in[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // one valid bit per pipeline stage; the diagonal data wavefront always
    // spans exactly 2N-1 register stages before the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            y_valid <= 1'b0;
            y_out <= '0;
        end else begin
            vld <= {vld[2*N-3:0], accept};
            y_valid <= vld[2*N-2];
            if (vld[2*N-2])
                for (int c = 0; c < N; c++)
                    y_out[c*ACC_WIDTH +: ACC_WIDTH] <= col[c];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_row
        // row 0 feeds the array directly so the accept edge is its first stage
        if (k == 0) begin : g_skew
            assign ent[k] = x_in[DATA_WIDTH-1:0];
        end else begin : g_skew
            logic signed [DATA_WIDTH-1:0] sk [k];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < k; i++)
                        sk[i] <= '0;
                end else begin
                    sk[0] <= x_in[k*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < k; i++)
                        sk[i] <= sk[i-1];
                end
            end
            assign ent[k] = sk[k-1];
        end
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DATA_WIDTH-1:0] act;
            logic signed [ACC_WIDTH-1:0] pin;
            logic signed [PW-1:0] prod;
            if (j == 0) begin : g_a
                assign act = ent[k];
            end else begin : g_a
                assign act = ar[k][j-1];
            end
            if (k == 0) begin : g_p
                assign pin = '0;
            end else begin : g_p
                assign pin = p[k-1][j];
            end
            assign prod = PW'(act) * PW'(w[k][j]);
            // sign-extend (or truncate) the product, sum wraps modulo 2^ACC_WIDTH
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    p[k][j] <= '0;
                else
                    p[k][j] <= pin + ACC_WIDTH'(prod);
            end
            if (j < N-1) begin : g_fwd
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        ar[k][j] <= '0;
                    else
                        ar[k][j] <= act;
                end
            end
        end
    end

    // column j leaves the array j cycles after column 0; delay it N-1-j more
    for (genvar j = 0; j < N; j++) begin : g_dsk
        if (j == N-1) begin : g_d
            assign col[j] = p[N-1][j];
        end else begin : g_d
            logic signed [ACC_WIDTH-1:0] d [N-1-j];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < N-1-j; i++)
                        d[i] <= '0;
                end else begin
                    d[0] <= p[N-1][j];
                    for (int i = 1; i < N-1-j; i++)
                        d[i] <= d[i-1];
                end
            end
            assign col[j] = d[N-2-j];
        end
    end
endmodule

// File: tb/tb_ws_systolic_array.sv
// tb_ws_systolic_array: directed bench for ws_systolic_array (N=4 main, N=2 wrap instance)
module tb_ws_systolic_array;
    logic clk, reset;
    logic load_weights, x_valid, weights_valid, x_ready, y_valid, busy;
    logic [63:0] w_in, x_in;
    logic [135:0] y_out;
    logic lw2, xv2, wv2, xr2, yv2, busy2;
    logic [7:0] w2, x2, y2;
    int vecs, fails, cyc;

    typedef struct { logic [63:0] x; logic [135:0] y; } vec_t;
    typedef struct { int due; logic [135:0] y; } exp_t;
    vec_t tbl [16];
    exp_t q [$];
    exp_t e;
    logic [255:0] id_m, kj_m;

    ws_systolic_array dut (
        .clk(clk), .reset(reset), .load_weights(load_weights), .w_in(w_in),
        .weights_valid(weights_valid), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready),
        .y_valid(y_valid), .y_out(y_out), .busy(busy)
    );

    ws_systolic_array #(.N(2), .DATA_WIDTH(4), .ACC_WIDTH(4)) dut2 (
        .clk(clk), .reset(reset), .load_weights(lw2), .w_in(w2),
        .weights_valid(wv2), .x_valid(xv2), .x_in(x2), .x_ready(xr2),
        .y_valid(yv2), .y_out(y2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] px(int a, int b, int c, int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [135:0] py(int a, int b, int c, int d);
        return {34'(d), 34'(c), 34'(b), 34'(a)};
    endfunction

    task automatic chk1(input string name, input logic got, input logic want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic chkv(input string name, input logic [135:0] got, input logic [135:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // every y_valid must match the oldest expectation, exactly on its due cycle
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            vecs++;
            fails++;
            $display("FAIL latency: no y_valid at cycle %0d", q[0].due);
            void'(q.pop_front());
        end
        if (y_valid) begin
            vecs++;
            if (q.size() == 0 || q[0].due != cyc) begin
                fails++;
                $display("FAIL y_valid: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                if (y_out !== e.y) begin
                    fails++;
                    $display("FAIL y_out: got %h want %h", y_out, e.y);
                end
            end
        end
    end

    task automatic send(input logic [63:0] x, input logic [135:0] y);
        x_valid = 1'b1;
        x_in = x;
        #1;
        chk1("x_ready", x_ready, 1'b1);
        q.push_back('{cyc + 8, y});
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic load(input logic [255:0] m);
        for (int i = 0; i < 4; i++) begin
            load_weights = 1'b1;
            w_in = m[i*64 +: 64];
            #1;
            chk1("x_ready_load", x_ready, 1'b0);
            if (i > 0) chk1("wv_loading", weights_valid, 1'b0);
            @(negedge clk);
        end
        load_weights = 1'b0;
        #1;
        chk1("wv_loaded", weights_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        vecs = 0; fails = 0; cyc = 0;
        reset = 1'b1; load_weights = 1'b0; x_valid = 1'b0; w_in = '0; x_in = '0;
        lw2 = 1'b0; xv2 = 1'b0; w2 = '0; x2 = '0;
        id_m = {px(0,0,0,1), px(0,0,1,0), px(0,1,0,0), px(1,0,0,0)};
        kj_m = {px(3,4,5,6), px(2,3,4,5), px(1,2,3,4), px(0,1,2,3)};
        // y_j = T + j*S with S = sum x_k, T = sum k*x_k for W[k][j] = k+j
        tbl[0]  = '{px(1,2,3,4),                  py(20,30,40,50)};
        tbl[1]  = '{px(-32768,32767,0,0),         py(32767,32766,32765,32764)};
        tbl[2]  = '{px(32767,32767,32767,32767),  py(196602,327670,458738,589806)};
        tbl[3]  = '{px(-32768,-32768,-32768,-32768), py(-196608,-327680,-458752,-589824)};
        tbl[4]  = '{px(0,0,0,0),                  py(0,0,0,0)};
        tbl[5]  = '{px(-1,1,-1,1),                py(2,2,2,2)};
        tbl[6]  = '{px(100,-200,300,-400),        py(-800,-1000,-1200,-1400)};
        tbl[7]  = '{px(5,0,0,0),                  py(0,5,10,15)};
        tbl[8]  = '{px(0,0,0,7),                  py(21,28,35,42)};
        tbl[9]  = '{px(-5,3,-7,2),                py(-5,-12,-19,-26)};
        tbl[10] = '{px(1234,-4321,999,-1),        py(-2326,-4415,-6504,-8593)};
        tbl[11] = '{px(32767,-32768,32767,-32768), py(-65538,-65540,-65542,-65544)};
        tbl[12] = '{px(-32768,0,0,32767),         py(98301,98300,98299,98298)};
        tbl[13] = '{px(2,4,8,16),                 py(68,98,128,158)};
        tbl[14] = '{px(-100,-100,50,50),          py(150,50,-50,-150)};
        tbl[15] = '{px(7,-7,7,-7),                py(-14,-14,-14,-14)};

        idle(2);
        chk1("rst_wv", weights_valid, 1'b0);
        chk1("rst_x_ready", x_ready, 1'b0);
        chk1("rst_y_valid", y_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkv("rst_y_out", y_out, '0);
        reset = 1'b0;

        // activations offered in EMPTY and throughout LOADING are dropped
        x_valid = 1'b1;
        x_in = px(1,1,1,1);
        #1;
        chk1("empty_x_ready", x_ready, 1'b0);
        idle(3);
        load(id_m);
        x_valid = 1'b0;
        idle(12);

        send(px(1,2,3,4), py(1,2,3,4));
        idle(12);

        load(kj_m);
        for (int i = 0; i < 16; i++) send(tbl[i].x, tbl[i].y);
        idle(12);

        // reload while busy is ignored; later beats still see the old matrix
        send(px(1,2,3,4), py(20,30,40,50));
        load_weights = 1'b1;
        w_in = px(0,0,0,1);
        #1;
        chk1("guard_busy", busy, 1'b1);
        chk1("guard_x_ready", x_ready, 1'b0);
        @(negedge clk);
        load_weights = 1'b0;
        #1;
        chk1("guard_wv", weights_valid, 1'b1);
        send(px(5,0,0,0), py(0,5,10,15));
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk1("busy_drain", busy, 1'b0);
        load(id_m);
        send(px(-3,7,0,9), py(-3,7,0,9));
        idle(12);

        // reload wins over a simultaneous activation beat
        x_valid = 1'b1;
        x_in = px(9,9,9,9);
        load(kj_m);
        x_valid = 1'b0;
        send(px(1,1,1,1), py(6,10,14,18));
        idle(12);

        // reset three beats into a stream of five
        for (int i = 0; i < 3; i++) send(tbl[i].x, tbl[i].y);
        x_valid = 1'b1;
        x_in = tbl[3].x;
        reset = 1'b1;
        #1;
        chk1("mid_rst_y_valid", y_valid, 1'b0);
        chkv("mid_rst_y_out", y_out, '0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_wv", weights_valid, 1'b0);
        chk1("mid_rst_x_ready", x_ready, 1'b0);
        q.delete();
        idle(2);
        reset = 1'b0;
        x_in = tbl[4].x;
        idle(1);
        x_valid = 1'b0;
        idle(12);
        chk1("post_rst_wv", weights_valid, 1'b0);
        load(kj_m);
        send(px(1,2,3,4), py(20,30,40,50));
        idle(12);

        // narrow instance: 4-bit results wrap modulo 16
        lw2 = 1'b1;
        w2 = 8'h77;
        idle(2);
        lw2 = 1'b0;
        #1;
        chk1("wrap_wv", wv2, 1'b1);
        xv2 = 1'b1;
        x2 = 8'h77;
        c0 = cyc;
        @(negedge clk);
        x2 = 8'h21;
        @(negedge clk);
        xv2 = 1'b0;
        for (int i = 0; i < 10 && !yv2; i++) @(negedge clk);
        chkv("wrap_latency", 136'(cyc - c0), 136'(4));
        chkv("wrap_y0", 136'(y2), 136'(8'h22));
        @(negedge clk);
        chk1("wrap_y_valid1", yv2, 1'b1);
        chkv("wrap_y1", 136'(y2), 136'(8'h55));
        idle(4);

        chkv("queue_empty", 136'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
